ray_issue: RTL
==============

RAY_ISSUE -- requirements
Module: ray_issue

Interface
REQ-001 Parameter Q_BITS, default 16, fractional bits of all signed 32-bit fixed-point vectors.
REQ-002 Parameter WIDTH, default 8, pixels per row (range 1..65535).
REQ-003 Parameter HEIGHT, default 8, rows per frame (range 1..65535).
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  frame request; sampled only in IDLE.
REQ-007 cam_origin[2:0]  input  32 signed each  camera origin (x,y,z).
REQ-008 dir_base[2:0]  input  32 signed each  ray direction for pixel (0,0).
REQ-009 dir_du[2:0]  input  32 signed each  direction increment per pixel column.
REQ-010 dir_dv[2:0]  input  32 signed each  direction increment per pixel row.
REQ-011 in_full[1:0]  input  1 each  full flags of the two downstream p_hit_1 input FIFOs.
REQ-012 in_wr_en[1:0]  output  1 each  write enables to the two downstream FIFOs.
REQ-013 origin[2:0]  output  32 signed each  ray origin presented with in_wr_en.
REQ-014 dir[2:0]  output  32 signed each  ray direction presented with in_wr_en.
REQ-015 pixel_x, pixel_y  output  16 each  coordinates of the ray currently presented.
REQ-016 busy  output  1  high in RUN.
REQ-017 done  output  1  single-cycle pulse after last ray written.

Function
REQ-018 States IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on write of pixel (WIDTH-1,HEIGHT-1); DONE->IDLE unconditionally next cycle.
REQ-019 On start in IDLE: capture cam_origin, dir_du, dir_dv into internal registers; load dir=dir_base, row accumulator=dir_base, pixel_x=pixel_y=0; input changes afterwards ignored until next IDLE.
REQ-020 in_wr_en[0] and in_wr_en[1] shall be identical, combinational: (state==RUN) & !in_full[0] & !in_full[1].
REQ-021 Either in_full bit high stalls both FIFOs; origin, dir, pixel_x, pixel_y held stable while stalled.
REQ-022 Each rising edge with in_wr_en high advances exactly one pixel; max throughput one ray per cycle.
REQ-023 Column advance (pixel_x<WIDTH-1): pixel_x+=1, dir+=dir_du per component.
REQ-024 Row advance (pixel_x==WIDTH-1): pixel_x=0, pixel_y+=1, row accumulator+=dir_dv, dir=row accumulator+dir_dv.
REQ-025 Arithmetic: 32-bit two's-complement add, wrap on overflow, no saturation, no multipliers.
REQ-026 origin outputs equal captured cam_origin for every ray in a frame.
REQ-027 First in_wr_en possible in first cycle of RUN (one cycle after start sampled).
REQ-028 start while RUN or DONE ignored; no restart, no queued request.
REQ-029 WIDTH=1 or HEIGHT=1 degenerate frames handled; 1x1 frame issues exactly one ray.
REQ-030 done high exactly in DONE; busy low in IDLE and DONE.

Reset
REQ-031 reset asserted: state=IDLE, in_wr_en=0, origin, dir, pixel_x, pixel_y, accumulators=0, busy=0, done=0, immediately (asynchronous).
REQ-032 reset mid-frame aborts without further writes; next frame requires new start after reset deasserts.

Verification
REQ-033 WIDTH=2,HEIGHT=2, dir_base=(0,0,0x00010000), du=(0x00008000,0,0), dv=(0,0x00008000,0), in_full=00 -> four consecutive writes, dir x/y = (0,0),(0x8000,0),(0,0x8000),(0x8000,0x8000), z=0x00010000, then done pulse.
REQ-034 Same frame, in_full[1]=1 for cycles 2-4 of RUN -> in_wr_en=00 during stall, presented ray unchanged, total four writes, order preserved.
REQ-035 cam_origin=(1,2,3) at start, changed to (9,9,9) mid-frame -> all rays carry origin (1,2,3).
REQ-036 start held high throughout frame -> exactly WIDTH*HEIGHT writes, single done pulse, next frame only after IDLE.
REQ-037 du=(0x7FFFFFFF,0,0), WIDTH=2 -> second ray dir x = dir_base.x+0x7FFFFFFF wrapped modulo 2^32.
REQ-038 reset asserted after second write of 4x4 frame -> outputs zero same cycle, no further in_wr_en, busy=0.

Source files
------------

// File: rtl/ray_issue_if.sv
// Downstream FIFO-side bundle of the ray issuer: one ray (origin, direction,
// pixel coordinates) plus write enables to, and full flags from, the two FIFOs.
interface ray_issue_if;
    logic        [1:0]  in_full;
    logic        [1:0]  in_wr_en;
    logic signed [31:0] origin [3];
    logic signed [31:0] dir    [3];
    logic        [15:0] pixel_x;
    logic        [15:0] pixel_y;

    modport master (
        input  in_full,
        output in_wr_en, origin, dir, pixel_x, pixel_y
    );

    modport slave (
        output in_full,
        input  in_wr_en, origin, dir, pixel_x, pixel_y
    );
endinterface

// File: rtl/ray_issue.sv
// Primary-ray issuer: walks a WIDTH x HEIGHT frame, generating one ray per pixel
// by incremental direction adds, and writes each ray to two FIFOs in lockstep.
module ray_issue #(
    parameter int Q_BITS = 16,
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic signed [31:0] cam_origin [3],
    input  logic signed [31:0] dir_base   [3],
    input  logic signed [31:0] dir_du     [3],
    input  logic signed [31:0] dir_dv     [3],
    ray_issue_if.master        ray,
    output logic               busy,
    output logic               done
);

    if (Q_BITS < 0 || Q_BITS > 31 || WIDTH < 1 || WIDTH > 65535 ||
        HEIGHT < 1 || HEIGHT > 65535) begin : g_bad_params
        $error("ray_issue: parameter out of range");
    end

    localparam logic [15:0] X_LAST = 16'(WIDTH - 1);
    localparam logic [15:0] Y_LAST = 16'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic signed [31:0] org_q [3], org_d [3];
    logic signed [31:0] dir_q [3], dir_d [3];
    logic signed [31:0] row_q [3], row_d [3];
    logic signed [31:0] du_q  [3], du_d  [3];
    logic signed [31:0] dv_q  [3], dv_d  [3];
    logic        [15:0] px_q, px_d;
    logic        [15:0] py_q, py_d;

    logic wr_en;
    logic last_pixel;

    assign wr_en      = (state_q == S_RUN) && !ray.in_full[0] && !ray.in_full[1];
    assign last_pixel = (px_q == X_LAST) && (py_q == Y_LAST);

    // row_q tracks the direction of the first pixel of the current row, so a
    // row change rebuilds dir from it instead of undoing the column adds.
    always_comb begin
        state_d = state_q;
        org_d   = org_q;
        dir_d   = dir_q;
        row_d   = row_q;
        du_d    = du_q;
        dv_d    = dv_q;
        px_d    = px_q;
        py_d    = py_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    org_d   = cam_origin;
                    du_d    = dir_du;
                    dv_d    = dir_dv;
                    dir_d   = dir_base;
                    row_d   = dir_base;
                    px_d    = '0;
                    py_d    = '0;
                end
            end
            S_RUN: begin
                if (wr_en) begin
                    if (last_pixel) begin
                        state_d = S_DONE;
                    end else if (px_q != X_LAST) begin
                        px_d = px_q + 16'd1;
                        for (int k = 0; k < 3; k++) begin
                            dir_d[k] = dir_q[k] + du_q[k];
                        end
                    end else begin
                        px_d = '0;
                        py_d = py_q + 16'd1;
                        for (int k = 0; k < 3; k++) begin
                            row_d[k] = row_q[k] + dv_q[k];
                            dir_d[k] = row_q[k] + dv_q[k];
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            org_q   <= '{default: '0};
            dir_q   <= '{default: '0};
            row_q   <= '{default: '0};
            du_q    <= '{default: '0};
            dv_q    <= '{default: '0};
            px_q    <= '0;
            py_q    <= '0;
        end else begin
            state_q <= state_d;
            org_q   <= org_d;
            dir_q   <= dir_d;
            row_q   <= row_d;
            du_q    <= du_d;
            dv_q    <= dv_d;
            px_q    <= px_d;
            py_q    <= py_d;
        end
    end

    assign ray.in_wr_en = {wr_en, wr_en};
    assign ray.origin   = org_q;
    assign ray.dir      = dir_q;
    assign ray.pixel_x  = px_q;
    assign ray.pixel_y  = py_q;
    assign busy         = (state_q == S_RUN);
    assign done         = (state_q == S_DONE);

endmodule
